// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues instruction-SRAM reads and
// keeps a decode-stage redirect alive across IF stalls.
module if_fetch #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          IF_TO_ID_WD = 33,
    parameter int          BR_WD       = 33,
    parameter int          STALL_WD    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;

    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_if_stop;
    logic        w_redirect_v;
    logic [31:0] w_redirect_a;
    logic [31:0] w_pc_inc;
    logic [31:0] w_next_pc;
    logic        w_active;
    logic        w_advance;
    logic        w_capture;
    logic        w_unused_stall;

    assign w_br_e         = br_bus[32];
    assign w_br_addr      = br_bus[31:0];
    assign w_if_stop      = stall[0];
    // Only the IF bit matters here; ID bubbles are handled in ID.
    assign w_unused_stall = ^stall[STALL_WD-1:1];

    // A live branch outranks a redirect parked during an earlier stall.
    assign w_redirect_v = w_br_e | r_pend_valid;
    assign w_redirect_a = w_br_e ? w_br_addr : r_pend_addr;
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_next_pc    = w_redirect_v ? w_redirect_a : w_pc_inc;

    assign w_active  = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign w_advance = w_active && !w_if_stop;
    assign w_capture = w_active && w_if_stop && w_br_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RST;
        case (r_state)
            ST_RST:  w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = w_if_stop ? ST_HOLD : ST_RUN;
            ST_HOLD: w_state_nxt = w_if_stop ? ST_HOLD : ST_RUN;
            default: w_state_nxt = ST_RST;
        endcase
    end

    always_comb begin
        inst_sram_en   = 1'b0;
        inst_sram_addr = r_pc;
        case (r_state)
            ST_RUN, ST_HOLD: begin
                inst_sram_en   = 1'b1;
                // A stalled fetch re-reads the held instruction.
                inst_sram_addr = w_if_stop ? r_pc : w_next_pc;
            end
            default: begin
                inst_sram_en   = 1'b0;
                inst_sram_addr = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= PC_INIT;
            r_ce         <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 32'd0;
        end else if (w_advance) begin
            r_pc         <= w_next_pc;
            r_ce         <= 1'b1;
            r_pend_valid <= 1'b0;
        end else if (w_capture) begin
            // Later redirects within one stall overwrite earlier ones.
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_br_addr;
        end
    end

    assign if_to_id_bus    = {r_ce, r_pc};
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed plus randomized bench for if_fetch against a behavioural model
// of the fetch rules (PC stepping, redirect priority, stall parking).
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic [32:0] br_bus = 33'd0;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int checks = 0;
    int errors = 0;

    // Model: current PC/ce, parked redirect, and "first cycle after reset".
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pa;
    logic        m_fresh;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC - 32'd4;
        m_ce    = 1'b0;
        m_pv    = 1'b0;
        m_pa    = 32'd0;
        m_fresh = 1'b1;
    endtask

    // Apply one cycle of inputs, check mid-cycle outputs, then clock the model.
    task automatic step(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        fetching;
        rst    = r;
        stall  = s;
        br_bus = {be, ba};
        #4;
        fetching = !m_fresh;
        if (be)        target = ba;
        else if (m_pv) target = m_pa;
        else           target = m_pc + 32'd4;
        exp_addr = s[0] ? m_pc : target;
        chk("sram_en", {63'd0, inst_sram_en}, {63'd0, fetching});
        chk("if_to_id_bus", {31'd0, if_to_id_bus}, {31'd0, m_ce, m_pc});
        if (fetching) chk("sram_addr", {32'd0, inst_sram_addr}, {32'd0, exp_addr});
        chk("sram_wen_wdata", {28'd0, inst_sram_wen, inst_sram_wdata}, 64'd0);
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (!s[0]) begin
            m_pc = target;
            m_ce = 1'b1;
            m_pv = 1'b0;
        end else if (be) begin
            m_pv = 1'b1;
            m_pa = ba;
        end
    endtask

    initial begin
        logic [5:0]  rs;
        logic        rb;
        logic [31:0] ra;
        logic        rr;

        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held, then RST cycle, then free run.
        step(1'b1, 6'd0, 1'b0, 32'd0);
        chk("reset_bus", {31'd0, if_to_id_bus}, {31'd0, 1'b0, RESET_PC - 32'd4});
        step(1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("first_fetch_bus", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0000});
        step(1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("pc_bfc00008", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'hBFC0_0008});

        // Taken branch.
        step(1'b0, 6'd0, 1'b1, 32'hBFC0_0100);
        chk("pc_after_branch", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0100});

        // Redirect in first of three stalled cycles.
        step(1'b0, 6'd1, 1'b1, 32'hBFC0_0200);
        step(1'b0, 6'd1, 1'b0, 32'd0);
        step(1'b0, 6'd1, 1'b0, 32'd0);
        chk("pc_held_in_stall", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0100});
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("pc_after_pending", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'hBFC0_0200});
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("pend_cleared", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'hBFC0_0204});

        // Two redirects in one stall: last wins.
        step(1'b0, 6'd1, 1'b1, 32'hBFC0_0300);
        step(1'b0, 6'd1, 1'b1, 32'hBFC0_0400);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("last_redirect_wins", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'hBFC0_0400});

        // Live branch on release beats pending; stall[1] ignored.
        step(1'b0, 6'd3, 1'b1, 32'hBFC0_0500);
        step(1'b0, 6'd2, 1'b1, 32'hBFC0_0600);
        chk("live_beats_pending", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'hBFC0_0600});

        // PC wrap and misaligned pass-through.
        step(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("pc_wrap", {32'd0, if_to_id_bus[31:0]}, 64'd0);
        step(1'b0, 6'd0, 1'b1, 32'h1234_5673);
        chk("misaligned", {32'd0, if_to_id_bus[31:0]}, {32'd0, 32'h1234_5673});

        // Reset while holding a pending redirect.
        step(1'b0, 6'd1, 1'b1, 32'hBFC0_0700);
        step(1'b0, 6'd1, 1'b0, 32'd0);
        step(1'b1, 6'd1, 1'b0, 32'd0);
        chk("reset_in_hold_ce", {63'd0, if_to_id_bus[32]}, 64'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("post_reset_fetch", {31'd0, if_to_id_bus}, {31'd0, 1'b1, 32'hBFC0_0000});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rs    = 6'($urandom);
            rs[0] = ($urandom_range(0, 9) < 4);
            rb    = ($urandom_range(0, 3) == 0);
            ra    = $urandom;
            rr    = ($urandom_range(0, 59) == 0);
            step(rr, rs, rb, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
